reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Sequences reset release for the RISC-V system after power-on and after any runtime reset event. It holds all domain resets asserted for a minimum time and waits for clock lock. It then releases the peripheral, memory and core resets in that fixed order, with a programmable gap between stages. It sits between the board reset/PLL and the per-domain reset bridges, and records the cause of the most recent reset for software.

## Interface
- HOLD_CYCLES, 16: cycles all resets stay asserted in ASSERT; legal range ≥1.
- STAGE_GAP, 4: cycles between successive domain releases; legal range ≥1.
- LOCK_TIMEOUT, 1024: WAIT_LOCK cycles before o_lock_timeout is flagged; legal range ≥1.
- i_aclk  in  1  system clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high; highest priority.
- i_pll_locked  in  1  clock-stable indication; already synchronous to i_aclk.
- i_sw_reset  in  1  software reset request; level sampled each cycle.
- i_wdt_expire  in  1  watchdog reset request; level sampled each cycle.
- o_periph_reset_n  out  1  peripheral domain reset, active-low.
- o_mem_reset_n  out  1  memory domain reset, active-low.
- o_core_reset_n  out  1  core domain reset, active-low.
- o_busy  out  1  high in every state except RUN.
- o_lock_timeout  out  1  sticky flag: lock not seen within LOCK_TIMEOUT.
- o_reset_cause  out  2  last cause: 00 i_reset, 01 lock loss, 10 software, 11 watchdog.

## Operation
- States: ASSERT, WAIT_LOCK, PERIPH, MEM, RUN.
- Outputs are decoded from the state register. They take new values in the same cycle the state changes, and are glitch-free (one-hot or registered decode).
  - o_periph_reset_n=1 in PERIPH, MEM and RUN.
  - o_mem_reset_n=1 in MEM and RUN.
  - o_core_reset_n=1 in RUN only.
- i_reset high: state ASSERT, cnt=0, all *_reset_n=0, o_busy=1, o_reset_cause=00, o_lock_timeout=0.
- ASSERT behaviour:
  - Entered with cnt=0.
  - Each cycle: if cnt==HOLD_CYCLES-1, go to WAIT_LOCK with cnt=0; else cnt++.
  - i_pll_locked is ignored in ASSERT.
- WAIT_LOCK behaviour:
  - i_pll_locked=1: go to PERIPH, cnt=0.
  - Otherwise cnt increments, saturating at LOCK_TIMEOUT. When cnt reaches LOCK_TIMEOUT-1 with no lock, o_lock_timeout is set.
  - Keeps waiting indefinitely.
- PERIPH and MEM behaviour:
  - cnt counts to STAGE_GAP-1, then goes to the next state (MEM, then RUN) with cnt=0.
- RUN: holds until a trigger.
- Triggers:
  - i_wdt_expire=1: cause 11.
  - i_sw_reset=1: cause 10.
  - i_pll_locked=0 while in PERIPH, MEM or RUN: cause 01.
- Trigger response, in any non-reset state:
  - Next state is ASSERT with cnt=0.
  - o_reset_cause is updated.
  - o_lock_timeout is cleared.
- Trigger in ASSERT: restarts the hold count at 0 and updates the cause.
- Low i_pll_locked in ASSERT or WAIT_LOCK is not a trigger.
- Simultaneous events, priority: i_reset > watchdog > software > lock loss. Only the winning cause is recorded.
- Counter width: $clog2(max(HOLD_CYCLES, STAGE_GAP, LOCK_TIMEOUT))+1; no wrap permitted.

## Timing
- E0 is the last rising edge with i_reset=1. With lock stable and no triggers:
  - Edge E_HOLD_CYCLES: enters WAIT_LOCK.
  - Edge E_HOLD_CYCLES+1: enters PERIPH.
  - E_HOLD_CYCLES+1+STAGE_GAP: enters MEM.
  - E_HOLD_CYCLES+1+2*STAGE_GAP: enters RUN (o_busy falls).
- Defaults give PERIPH at E17, MEM at E21 and RUN at E25.
- Trigger sampled at edge Ek: all *_reset_n are 0 immediately after Ek. Asynchronous assertion is not provided; domain bridges handle that.
- A trigger held high keeps the sequencer in ASSERT with cnt=0. Release timing counts from the last edge at which the trigger was sampled high.
- A mid-sequence reset (i_reset, or a trigger in PERIPH or MEM) aborts immediately. No partial release persists.

## Test plan
- Power-on with defaults, i_reset high 3 cycles, i_pll_locked=1 → periph_n rises at E17, mem_n at E21, core_n at E25; o_busy=0 from E25; cause=00.
- Lock arrives late: i_pll_locked rises at E40 → WAIT_LOCK E16..E40, PERIPH at E41, RUN at E49; o_lock_timeout stays 0.
- LOCK_TIMEOUT=8, lock never asserted → o_lock_timeout=1 at E24, all resets stay 0. Raise lock at E30 → PERIPH at E31, flag stays 1.
- In RUN, pulse i_wdt_expire and i_sw_reset together for 1 cycle → all resets 0 next cycle; cause=11; o_lock_timeout cleared; RUN reached 25 cycles later.
- i_pll_locked drops for 1 cycle while in MEM → immediate abort to ASSERT with all resets 0, cause=01; full 25-cycle resequence follows.
- i_sw_reset at ASSERT cnt=10 → cnt restarts at 0; WAIT_LOCK entered 16 cycles after that edge; cause=10.

Source files
------------

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: lock/trigger inputs and per-domain reset outputs of the reset sequencer
interface reset_sequencer_if;
    logic       i_pll_locked;
    logic       i_sw_reset;
    logic       i_wdt_expire;
    logic       o_periph_reset_n;
    logic       o_mem_reset_n;
    logic       o_core_reset_n;
    logic       o_busy;
    logic       o_lock_timeout;
    logic [1:0] o_reset_cause;

    modport master (
        input  i_pll_locked, i_sw_reset, i_wdt_expire,
        output o_periph_reset_n, o_mem_reset_n, o_core_reset_n, o_busy, o_lock_timeout, o_reset_cause
    );

    modport slave (
        output i_pll_locked, i_sw_reset, i_wdt_expire,
        input  o_periph_reset_n, o_mem_reset_n, o_core_reset_n, o_busy, o_lock_timeout, o_reset_cause
    );
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer: holds domain resets, waits for PLL lock, then releases periph, mem, core in order
module reset_sequencer #(
    parameter int HOLD_CYCLES  = 16,
    parameter int STAGE_GAP    = 4,
    parameter int LOCK_TIMEOUT = 1024
) (
    input logic i_aclk,
    input logic i_reset,
    reset_sequencer_if.master bus
);
    localparam int MAX_HS  = HOLD_CYCLES > STAGE_GAP ? HOLD_CYCLES : STAGE_GAP;
    localparam int MAX_ALL = MAX_HS > LOCK_TIMEOUT ? MAX_HS : LOCK_TIMEOUT;
    localparam int CW      = $clog2(MAX_ALL) + 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] LOCK_MAX  = CW'(LOCK_TIMEOUT);

    typedef enum logic [2:0] {S_ASSERT, S_WAIT_LOCK, S_PERIPH, S_MEM, S_RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    cause_q, cause_d;
    logic          timeout_q, timeout_d;
    logic          periph_n_q, periph_n_d;
    logic          mem_n_q, mem_n_d;
    logic          core_n_q, core_n_d;
    logic          busy_q, busy_d;
    logic          lock_loss, trigger;

    // Next state, counter, cause and flag; outputs decoded from next state so they flip with the state flop
    always_comb begin
        lock_loss = (state_q inside {S_PERIPH, S_MEM, S_RUN}) && !bus.i_pll_locked;
        trigger   = bus.i_wdt_expire || bus.i_sw_reset || lock_loss;
        cause_d   = bus.i_wdt_expire ? 2'b11 : bus.i_sw_reset ? 2'b10 : lock_loss ? 2'b01 : cause_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (trigger) begin
            state_d   = S_ASSERT;
            cnt_d     = '0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                S_ASSERT: begin
                    state_d = cnt_q == HOLD_LAST ? S_WAIT_LOCK : S_ASSERT;
                    cnt_d   = cnt_q == HOLD_LAST ? '0 : cnt_q + 1'b1;
                end
                S_WAIT_LOCK: begin
                    state_d   = bus.i_pll_locked ? S_PERIPH : S_WAIT_LOCK;
                    cnt_d     = bus.i_pll_locked ? '0 : cnt_q == LOCK_MAX ? cnt_q : cnt_q + 1'b1;
                    timeout_d = timeout_q || (!bus.i_pll_locked && cnt_q >= LOCK_LAST);
                end
                S_PERIPH, S_MEM: begin
                    state_d = cnt_q != GAP_LAST ? state_q : state_q == S_PERIPH ? S_MEM : S_RUN;
                    cnt_d   = cnt_q == GAP_LAST ? '0 : cnt_q + 1'b1;
                end
                S_RUN: state_d = S_RUN;
                default: begin
                    state_d = S_ASSERT;
                    cnt_d   = '0;
                end
            endcase
        end
        periph_n_d = state_d inside {S_PERIPH, S_MEM, S_RUN};
        mem_n_d    = state_d inside {S_MEM, S_RUN};
        core_n_d   = state_d == S_RUN;
        busy_d     = state_d != S_RUN;
    end

    // State and registered outputs; i_reset forces the fully-asserted state
    always_ff @(posedge i_aclk) begin
        if (i_reset) begin
            state_q    <= S_ASSERT;
            cnt_q      <= '0;
            cause_q    <= 2'b00;
            timeout_q  <= 1'b0;
            periph_n_q <= 1'b0;
            mem_n_q    <= 1'b0;
            core_n_q   <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cause_q    <= cause_d;
            timeout_q  <= timeout_d;
            periph_n_q <= periph_n_d;
            mem_n_q    <= mem_n_d;
            core_n_q   <= core_n_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.o_periph_reset_n = periph_n_q;
    assign bus.o_mem_reset_n    = mem_n_q;
    assign bus.o_core_reset_n   = core_n_q;
    assign bus.o_busy           = busy_q;
    assign bus.o_lock_timeout   = timeout_q;
    assign bus.o_reset_cause    = cause_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed scenarios checked every cycle against a timestamp-based model
module tb_reset_sequencer;
    localparam int H = 16;
    localparam int G = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lock = 1'b1;
    logic sw = 1'b0;
    logic wdt = 1'b0;

    int n_chk = 0;
    int n_pass = 0;
    int ed = 0;
    int e0 = 0;

    always #5 clk = ~clk;

    reset_sequencer_if bus0 ();
    reset_sequencer_if bus1 ();
    assign bus0.i_pll_locked = lock;
    assign bus0.i_sw_reset   = sw;
    assign bus0.i_wdt_expire = wdt;
    assign bus1.i_pll_locked = lock;
    assign bus1.i_sw_reset   = sw;
    assign bus1.i_wdt_expire = wdt;

    reset_sequencer dut0 (.i_aclk(clk), .i_reset(rst), .bus(bus0));
    reset_sequencer #(.LOCK_TIMEOUT(8)) dut1 (.i_aclk(clk), .i_reset(rst), .bus(bus1));

    // Model: each instance remembers the edge of its last restart and the edge it entered PERIPH
    int         lt[2] = '{1024, 8};
    int         restart[2];
    int         periph_at[2];
    logic [1:0] m_cause[2];
    logic       m_to[2];
    logic       valid = 1'b0;

    // Phase after edge m: 0 hold, 1 waiting for lock, 2 periph, 3 mem, 4 run
    function automatic int phase(int i, int m);
        if (periph_at[i] < 0) return (m - restart[i] < H) ? 0 : 1;
        if (m - periph_at[i] < G) return 2;
        if (m - periph_at[i] < 2 * G) return 3;
        return 4;
    endfunction

    always @(posedge clk) begin
        ed = ed + 1;
        for (int i = 0; i < 2; i++) begin
            int ps;
            ps = valid ? phase(i, ed - 1) : 0;
            if (rst) begin
                restart[i] = ed; periph_at[i] = -1; m_cause[i] = 2'b00; m_to[i] = 1'b0;
            end else if (valid) begin
                if (wdt || sw || (!lock && ps >= 2)) begin
                    restart[i] = ed; periph_at[i] = -1; m_to[i] = 1'b0;
                    m_cause[i] = wdt ? 2'b11 : sw ? 2'b10 : 2'b01;
                end else if (ps == 1) begin
                    if (lock) periph_at[i] = ed;
                    else if (ed - restart[i] - H >= lt[i]) m_to[i] = 1'b1;
                end
            end
        end
        if (rst) valid = 1'b1;
    end

    task automatic chk(input string nm, input logic [1:0] got, input logic [1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at edge %0d: got=%0d expected=%0d", nm, ed, got, exp);
    endtask

    task automatic cmp(input int i, input logic p, input logic m, input logic c, input logic b,
                       input logic t, input logic [1:0] ca);
        int st;
        st = phase(i, ed);
        chk($sformatf("u%0d periph_n", i), {1'b0, p}, {1'b0, st >= 2});
        chk($sformatf("u%0d mem_n", i), {1'b0, m}, {1'b0, st >= 3});
        chk($sformatf("u%0d core_n", i), {1'b0, c}, {1'b0, st == 4});
        chk($sformatf("u%0d busy", i), {1'b0, b}, {1'b0, st != 4});
        chk($sformatf("u%0d lock_timeout", i), {1'b0, t}, {1'b0, m_to[i]});
        chk($sformatf("u%0d cause", i), ca, m_cause[i]);
    endtask

    always @(negedge clk) begin
        if (valid) begin
            cmp(0, bus0.o_periph_reset_n, bus0.o_mem_reset_n, bus0.o_core_reset_n, bus0.o_busy,
                bus0.o_lock_timeout, bus0.o_reset_cause);
            cmp(1, bus1.o_periph_reset_n, bus1.o_mem_reset_n, bus1.o_core_reset_n, bus1.o_busy,
                bus1.o_lock_timeout, bus1.o_reset_cause);
        end
    end

    task automatic upto(input int k);
        while (ed < e0 + k) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        e0 = ed;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        // Power-on with lock stable
        do_reset();
        chk("por reset periph_n", {1'b0, bus0.o_periph_reset_n}, 2'd0);
        chk("por reset busy", {1'b0, bus0.o_busy}, 2'd1);
        upto(16); chk("por E16 periph_n", {1'b0, bus0.o_periph_reset_n}, 2'd0);
        upto(17); chk("por E17 periph_n", {1'b0, bus0.o_periph_reset_n}, 2'd1);
        chk("por E17 mem_n", {1'b0, bus0.o_mem_reset_n}, 2'd0);
        upto(21); chk("por E21 mem_n", {1'b0, bus0.o_mem_reset_n}, 2'd1);
        upto(24); chk("por E24 busy", {1'b0, bus0.o_busy}, 2'd1);
        upto(25); chk("por E25 core_n", {1'b0, bus0.o_core_reset_n}, 2'd1);
        chk("por E25 busy", {1'b0, bus0.o_busy}, 2'd0);
        chk("por cause", bus0.o_reset_cause, 2'b00);
        // Late lock, rising after E40
        lock = 1'b0;
        do_reset();
        upto(40); lock = 1'b1;
        chk("late E40 periph_n", {1'b0, bus0.o_periph_reset_n}, 2'd0);
        upto(41); chk("late E41 periph_n", {1'b0, bus0.o_periph_reset_n}, 2'd1);
        upto(48); chk("late E48 busy", {1'b0, bus0.o_busy}, 2'd1);
        upto(49); chk("late E49 busy", {1'b0, bus0.o_busy}, 2'd0);
        chk("late timeout", {1'b0, bus0.o_lock_timeout}, 2'd0);
        // Lock never arrives on the short-timeout instance, raised after E30
        lock = 1'b0;
        do_reset();
        upto(23); chk("to E23 flag", {1'b0, bus1.o_lock_timeout}, 2'd0);
        upto(24); chk("to E24 flag", {1'b0, bus1.o_lock_timeout}, 2'd1);
        chk("to E24 periph_n", {1'b0, bus1.o_periph_reset_n}, 2'd0);
        upto(30); lock = 1'b1;
        chk("to E30 periph_n", {1'b0, bus1.o_periph_reset_n}, 2'd0);
        upto(31); chk("to E31 periph_n", {1'b0, bus1.o_periph_reset_n}, 2'd1);
        chk("to E31 flag", {1'b0, bus1.o_lock_timeout}, 2'd1);
        // Watchdog and software together from RUN
        upto(45);
        chk("wdt pre core_n", {1'b0, bus1.o_core_reset_n}, 2'd1);
        wdt = 1'b1; sw = 1'b1;
        @(negedge clk);
        wdt = 1'b0; sw = 1'b0; e0 = ed;
        chk("wdt periph_n", {1'b0, bus1.o_periph_reset_n}, 2'd0);
        chk("wdt core_n", {1'b0, bus0.o_core_reset_n}, 2'd0);
        chk("wdt cause", bus0.o_reset_cause, 2'b11);
        chk("wdt flag cleared", {1'b0, bus1.o_lock_timeout}, 2'd0);
        upto(24); chk("wdt +24 busy", {1'b0, bus0.o_busy}, 2'd1);
        upto(25); chk("wdt +25 busy", {1'b0, bus0.o_busy}, 2'd0);
        // Lock loss while in MEM
        upto(22); lock = 1'b0;
        chk("mem pre mem_n", {1'b0, bus0.o_mem_reset_n}, 2'd1);
        @(negedge clk);
        lock = 1'b1; e0 = ed;
        chk("ll periph_n", {1'b0, bus0.o_periph_reset_n}, 2'd0);
        chk("ll cause", bus0.o_reset_cause, 2'b01);
        upto(24); chk("ll +24 busy", {1'b0, bus0.o_busy}, 2'd1);
        upto(25); chk("ll +25 core_n", {1'b0, bus0.o_core_reset_n}, 2'd1);
        // Software reset at hold count 10
        do_reset();
        upto(10); sw = 1'b1;
        @(negedge clk);
        sw = 1'b0; e0 = ed;
        chk("sw cause", bus0.o_reset_cause, 2'b10);
        upto(16); chk("sw +16 periph_n", {1'b0, bus0.o_periph_reset_n}, 2'd0);
        upto(17); chk("sw +17 periph_n", {1'b0, bus0.o_periph_reset_n}, 2'd1);
        // i_reset in PERIPH aborts immediately
        upto(18); rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; e0 = ed;
        chk("abort periph_n", {1'b0, bus0.o_periph_reset_n}, 2'd0);
        chk("abort cause", bus0.o_reset_cause, 2'b00);
        upto(30);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
